lab1_sys_buttons_ctrl: RTL and testbench
========================================

LAB1_SYS_BUTTONS_CTRL -- requirements
Module: lab1_sys_buttons_ctrl

Interface
REQ-001 Parameter WIDTH, 5: number of button inputs, 1..32.
REQ-002 Parameter DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a new level, >=2.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 address  input  2  Avalon-MM word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 read  input  1  read strobe, qualified by chipselect.
REQ-008 write  input  1  write strobe, qualified by chipselect.
REQ-009 writedata  input  32  write data.
REQ-010 readdata  output  32  registered read data.
REQ-011 in_port  input  WIDTH  raw, asynchronous, active-low button levels.
REQ-012 irq  output  1  level interrupt, active-high.

Function
REQ-013 The block SHALL pass in_port through a 2-flop synchronizer before any other use.
REQ-014 Per bit, the block SHALL hold a debounced level plus a counter: synced == debounced -> counter cleared; otherwise counter increments; at DEBOUNCE_CYCLES-1 the debounced bit takes the synced value and the counter clears.
REQ-015 Any mismatch cycle ending before acceptance SHALL clear the counter, so glitches shorter than DEBOUNCE_CYCLES are never accepted.
REQ-016 A debounced 1->0 transition (press) on bit i SHALL set edgecapture[i] in the cycle after the transition.
REQ-017 Register map, word address: 0 = debounced data (RO); 1 = synchronized raw data (RO); 2 = irqmask (RW, bits WIDTH-1:0); 3 = edgecapture (RW1C).
REQ-018 Unused readdata bits SHALL read 0; writes to addresses 0 and 1 SHALL be ignored.
REQ-019 Read latency SHALL be exactly 1 cycle: readdata updates on the clock edge after chipselect&read and holds otherwise.
REQ-020 Writing 1 to edgecapture bit i SHALL clear it; writing 0 SHALL leave it unchanged.
REQ-021 If a new press on bit i coincides with a write-1 clear of bit i, the bit SHALL end set (set wins).
REQ-022 irq SHALL be registered: irq <= |(edgecapture & irqmask), i.e. 1 cycle after the capture/mask change.
REQ-023 A read and write in the same cycle SHALL be ignored entirely (no update, readdata held).

Reset
REQ-024 With reset_n low at a clk edge, the block SHALL load: synchronizer flops and debounced level all ones (released), counters 0, irqmask 0, edgecapture 0, readdata 0, irq 0.
REQ-025 Reset asserted mid-debounce SHALL abandon the count; no edge SHALL be captured as a result of reset or its release.

Configuration
REQ-026 Macro LAB1_SYS_BUTTONS_DEBOUNCE_EN defined: debounce counters per REQ-014/015 are built.
REQ-027 Macro undefined: no counters; the debounced level SHALL equal the synchronizer output registered once, DEBOUNCE_CYCLES SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification (bench uses WIDTH=5, DEBOUNCE_CYCLES=4, macro defined unless noted)
REQ-028 Reset: hold reset_n low 3 cycles -> readdata=0, irq=0; read addr 0 -> 0x0000001F.
REQ-029 Clean press: in_port[2] 1->0 held 10 cycles -> addr 0 reads 0x1B after 2 sync + 4 debounce cycles; addr 3 reads 0x04; irq stays 0 (mask 0).
REQ-030 Glitch: in_port[0] low for 3 cycles then high -> addr 0 stays 0x1F, edgecapture stays 0.
REQ-031 IRQ: write addr 2 = 0x04, press bit 2 -> irq rises 1 cycle after edgecapture[2]; write addr 3 = 0x04 -> edgecapture 0, irq falls 1 cycle later.
REQ-032 Collision: write addr 3 = 0x01 in the same cycle bit 0 debounced press lands -> edgecapture[0]=1.
REQ-033 Macro undefined: in_port[1] low 1 cycle -> edgecapture[1]=1 after 3 cycles; read latency 1 cycle on every address.

Source files
------------

// File: rtl/lab1_sys_buttons_ctrl.sv
// Debounced push-button PIO with an Avalon-MM slave: data, raw, irqmask and edgecapture registers.
// Define LAB1_SYS_BUTTONS_DEBOUNCE_EN to build the per-bit debounce counters.

module lab1_sys_buttons_lane #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic sync_o,
  output logic db_o,
  output logic fall_o
);
  logic s1_q, s2_q, db_q, db_d;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("DEBOUNCE_CYCLES must be >= 2");
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      db_q <= 1'b1;
    end else begin
      s1_q <= pin_i;
      s2_q <= s1_q;
      db_q <= db_d;
    end
  end

`ifdef LAB1_SYS_BUTTONS_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Any cycle where the synced level agrees with the accepted one restarts the count.
  always_comb begin
    cnt_d = '0;
    db_d  = db_q;
    if (s2_q != db_q) begin
      if (cnt_q == LAST) db_d  = s2_q;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end
`else
  assign db_d = s2_q;
`endif

  assign sync_o = s2_q;
  assign db_o   = db_q;
  assign fall_o = db_q & ~db_d;
endmodule

module lab1_sys_buttons_ctrl #(
  parameter int unsigned WIDTH           = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] sync, db, fall;
  logic [WIDTH-1:0] mask_q, ec_q, ec_d;
  logic [31:0]      rdata_q, rd_mux;
  logic             irq_q, rd_en, wr_en;

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_lane
    lab1_sys_buttons_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .pin_i  (in_port[i]),
      .sync_o (sync[i]),
      .db_o   (db[i]),
      .fall_o (fall[i])
    );
  end

  // A simultaneous read and write is dropped as a whole.
  assign rd_en = chipselect & read & ~write;
  assign wr_en = chipselect & write & ~read;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[WIDTH-1:0] = db;
      2'd1: rd_mux[WIDTH-1:0] = sync;
      2'd2: rd_mux[WIDTH-1:0] = mask_q;
      default: rd_mux[WIDTH-1:0] = ec_q;
    endcase
  end

  // Press is OR-ed in after the clear so it wins a same-cycle collision.
  always_comb begin
    ec_d = ec_q;
    if (wr_en && address == 2'd3) ec_d = ec_q & ~writedata[WIDTH-1:0];
    ec_d = ec_d | fall;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q  <= '0;
      ec_q    <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      ec_q  <= ec_d;
      irq_q <= |(ec_q & mask_q);
      if (wr_en && address == 2'd2) mask_q <= writedata[WIDTH-1:0];
      if (rd_en) rdata_q <= rd_mux;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;
endmodule

// File: tb/tb_lab1_sys_buttons_ctrl.sv
// Self-checking bench for lab1_sys_buttons_ctrl: register table, timed corner sequences, random vs model.
module tb_lab1_sys_buttons_ctrl;
  localparam int W  = 5;
  localparam int DC = 4;
`ifdef LAB1_SYS_BUTTONS_DEBOUNCE_EN
  localparam int LAT = 2 + DC;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = '0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [W-1:0] in_port = '1;
  logic        irq;
  int checks = 0, errors = 0;

  lab1_sys_buttons_ctrl #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  // Reference model: 2-deep delay line, then a level is accepted once the synced
  // value has disagreed with the accepted one for DC samples in a row.
  logic [W-1:0] m_sa = '1, m_sb = '1, m_db = '1, m_ec = '0, m_mask = '0;
  logic [W-1:0] m_dbn, m_ecn, m_clr;
  logic [31:0]  m_rd = '0, m_rdn;
  logic         m_irq = 1'b0;
  int           m_run [W];
  int           m_runn [W];

  initial for (int i = 0; i < W; i++) m_run[i] = 0;

  always_comb begin
    m_dbn = m_db;
    for (int i = 0; i < W; i++) begin
`ifdef LAB1_SYS_BUTTONS_DEBOUNCE_EN
      m_runn[i] = (m_sb[i] != m_db[i]) ? m_run[i] + 1 : 0;
      if (m_runn[i] == DC) begin
        m_dbn[i]  = m_sb[i];
        m_runn[i] = 0;
      end
`else
      m_runn[i] = 0;
      m_dbn[i]  = m_sb[i];
`endif
    end
    m_rdn = m_rd;
    if (chipselect && read && !write)
      case (address)
        2'd0: m_rdn = 32'(m_db);
        2'd1: m_rdn = 32'(m_sb);
        2'd2: m_rdn = 32'(m_mask);
        default: m_rdn = 32'(m_ec);
      endcase
    m_clr = (chipselect && write && !read && address == 2'd3) ? writedata[W-1:0] : '0;
    m_ecn = (m_ec & ~m_clr) | (m_db & ~m_dbn);
  end

  always @(posedge clk) begin
    if (!reset_n) begin
      m_sa <= '1; m_sb <= '1; m_db <= '1; m_ec <= '0; m_mask <= '0;
      m_rd <= '0; m_irq <= 1'b0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin
      m_sa <= in_port; m_sb <= m_sa; m_db <= m_dbn; m_ec <= m_ecn;
      m_rd <= m_rdn; m_irq <= |(m_ec & m_mask);
      for (int i = 0; i < W; i++) m_run[i] <= m_runn[i];
      if (chipselect && write && !read && address == 2'd2) m_mask <= writedata[W-1:0];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input bit cs, input bit rd, input bit wr, input logic [1:0] a, input logic [31:0] d);
    chipselect = cs; read = rd; write = wr; address = a; writedata = d;
    cyc(1);
    chipselect = 0; read = 0; write = 0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    bus(1, 1, 0, a, '0);
    chk(name, readdata, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus(1, 0, 1, a, d);
  endtask

  typedef struct {
    bit          cs, rd, wr;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vt [15];

  initial begin
    vt[0]  = '{1, 0, 1, 2'd2, 32'h0000_0015, 32'h1F};
    vt[1]  = '{1, 1, 0, 2'd2, 32'h0,         32'h15};
    vt[2]  = '{1, 0, 1, 2'd0, 32'hFFFF_FFFF, 32'h15};
    vt[3]  = '{1, 1, 0, 2'd0, 32'h0,         32'h1F};
    vt[4]  = '{1, 1, 0, 2'd1, 32'h0,         32'h1F};
    vt[5]  = '{1, 0, 1, 2'd2, 32'hFFFF_FFE3, 32'h1F};
    vt[6]  = '{1, 1, 0, 2'd2, 32'h0,         32'h03};
    vt[7]  = '{1, 1, 1, 2'd2, 32'h0,         32'h03};
    vt[8]  = '{1, 1, 0, 2'd2, 32'h0,         32'h03};
    vt[9]  = '{1, 0, 1, 2'd3, 32'h1F,        32'h03};
    vt[10] = '{1, 1, 0, 2'd3, 32'h0,         32'h00};
    vt[11] = '{1, 0, 1, 2'd2, 32'h0,         32'h00};
    vt[12] = '{0, 1, 0, 2'd0, 32'h0,         32'h00};
    vt[13] = '{1, 1, 0, 2'd2, 32'h0,         32'h00};
    vt[14] = '{1, 1, 0, 2'd1, 32'h0,         32'h1F};

    // Reset
    reset_n = 0;
    cyc(3);
    chk("reset_readdata", readdata, 32'h0);
    chk("reset_irq", 32'(irq), 32'h0);
    reset_n = 1;
    bus_read(2'd0, 32'h1F, "reset_data");

    // Register map table
    foreach (vt[i]) begin
      bus(vt[i].cs, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd);
      chk($sformatf("table_%0d", i), readdata, vt[i].exp_rd);
      chk($sformatf("table_irq_%0d", i), 32'(irq), 32'h0);
    end

    // Clean press on bit 2 with exact acceptance latency
    in_port = 5'b11011;
    cyc(LAT - 1);
    bus_read(2'd0, 32'h1F, "press_before_accept");
    bus_read(2'd0, 32'h1B, "press_accepted");
    bus_read(2'd3, 32'h04, "press_edge");
    chk("press_irq_masked", 32'(irq), 32'h0);
    cyc(3);
    in_port = '1;
    cyc(8);
    bus_read(2'd0, 32'h1F, "release_data");
    bus_read(2'd3, 32'h04, "release_no_edge");
    bus_write(2'd3, 32'h04);
    bus_read(2'd3, 32'h00, "w1c_clear");

`ifdef LAB1_SYS_BUTTONS_DEBOUNCE_EN
    // Glitch one cycle short of acceptance, then exactly long enough
    in_port[0] = 0; cyc(DC - 1); in_port = '1; cyc(8);
    bus_read(2'd0, 32'h1F, "glitch_data");
    bus_read(2'd3, 32'h00, "glitch_edge");
    in_port[0] = 0; cyc(DC); in_port = '1; cyc(10);
    bus_read(2'd3, 32'h01, "min_press_edge");
    bus_write(2'd3, 32'h01);
`else
    // One-cycle low is passed straight through without debounce
    in_port[1] = 0; cyc(1); in_port = '1; cyc(1);
    bus_read(2'd3, 32'h00, "nodb_edge_early");
    bus_read(2'd3, 32'h02, "nodb_edge");
    bus_read(2'd0, 32'h1F, "nodb_data");
    bus_write(2'd3, 32'h02);
`endif

    // Interrupt rise and fall
    bus_write(2'd2, 32'h04);
    in_port[2] = 0;
    cyc(LAT);
    chk("irq_lag", 32'(irq), 32'h0);
    cyc(1);
    chk("irq_rise", 32'(irq), 32'h1);
    bus_read(2'd3, 32'h04, "irq_edge");
    bus_write(2'd3, 32'h04);
    chk("irq_hold", 32'(irq), 32'h1);
    cyc(1);
    chk("irq_fall", 32'(irq), 32'h0);
    in_port = '1;
    cyc(8);
    chk("irq_release", 32'(irq), 32'h0);

    // Press landing in the same cycle as a write-1 clear
    in_port[0] = 0;
    cyc(LAT - 1);
    bus_write(2'd3, 32'h01);
    bus_read(2'd3, 32'h01, "collision_set_wins");
    bus_write(2'd3, 32'h01);
    bus_read(2'd3, 32'h00, "collision_cleared");
    in_port = '1;
    cyc(8);

    // Reset in the middle of a debounce
    in_port[1] = 0;
    cyc(3);
    reset_n = 0; in_port = '1;
    cyc(2);
    reset_n = 1;
    cyc(8);
    bus_read(2'd3, 32'h00, "reset_mid_edge");
    bus_read(2'd2, 32'h00, "reset_mid_mask");
    chk("reset_mid_irq", 32'(irq), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r, op;
      r = $urandom_range(0, 99);
      if (r < 5) in_port[$urandom_range(0, W - 1)] ^= 1'b1;
      reset_n = !(n >= 1500 && n < 1502);
      op = $urandom_range(0, 9);
      chipselect = ($urandom_range(0, 7) != 0);
      read       = (op <= 3) || (op == 6);
      write      = (op == 4) || (op == 5) || (op == 6);
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      cyc(1);
      chk("rand_readdata", readdata, m_rd);
      chk("rand_irq", 32'(irq), 32'(m_irq));
    end
    chipselect = 0; read = 0; write = 0; reset_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
